// File: rtl/gcd_job_sequencer_pkg.sv
// Shared definitions for the GCD job sequencer: FSM state encoding and the
// default parameter values that must agree with the iterative GCD core.
package gcd_job_sequencer_pkg;

   // Operand/result width of the GCD core this sequencer drives.
   localparam int GCD_WIDTH = 8;

   // Default number of WAIT cycles before a job is declared hung.
   localparam int DEFAULT_TIMEOUT = 255;

   // Default width of the WAIT-cycle counter (must exceed TIMEOUT-1).
   localparam int DEFAULT_CNT_W = 8;

   // Job sequencing states; encodings are fixed so the core-side logic
   // and debug tooling agree on what each value means.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_ARM  = 3'd2,
      S_WAIT = 3'd3,
      S_DONE = 3'd4
   } state_e;

endpackage : gcd_job_sequencer_pkg

// File: rtl/gcd_job_sequencer.sv
// Initiator for an iterative GCD core. Takes operand pairs from a valid/ready
// channel, pulses load once per job, waits for TC (or gives up after TIMEOUT
// WAIT cycles), and hands the result to a valid/ready output channel. Jobs
// with a zero operand are answered locally without touching the core.
module gcd_job_sequencer
   import gcd_job_sequencer_pkg::*;
#(
   parameter int WIDTH   = GCD_WIDTH,
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int CNT_W   = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             async_reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_m,
   input  logic [WIDTH-1:0] in_n,
   output logic [WIDTH-1:0] M,
   output logic [WIDTH-1:0] N,
   output logic             load,
   input  logic [WIDTH-1:0] GCD,
   input  logic             TC,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_gcd,
   output logic             res_timeout,
   output logic             busy
);

   // Counter value reached on the last WAIT cycle that may still see TC.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic [WIDTH-1:0] res_gcd_q, res_gcd_d;
   logic             res_timeout_q, res_timeout_d;
   logic             load_q, load_d;
   logic             res_valid_q, res_valid_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next-state logic: job progression, operand capture, timeout counting and
   // result capture; registered outputs are decoded from the next state so
   // they line up with the state they describe.
   always_comb begin
      state_d       = state_q;
      m_d           = m_q;
      n_d           = n_q;
      res_gcd_d     = res_gcd_q;
      res_timeout_d = res_timeout_q;
      cnt_d         = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               m_d = in_m;
               n_d = in_n;
               if ((in_m == '0) || (in_n == '0)) begin
                  res_gcd_d     = in_m | in_n;
                  res_timeout_d = 1'b0;
                  state_d       = S_DONE;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            state_d = S_ARM;
         end
         S_ARM: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (TC) begin
               res_gcd_d     = GCD;
               res_timeout_d = 1'b0;
               state_d       = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               res_gcd_d     = '0;
               res_timeout_d = 1'b1;
               state_d       = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      load_d      = (state_d == S_LOAD);
      res_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   // All sequencer state, operand and result registers; reset drops any job.
   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         state_q       <= S_IDLE;
         m_q           <= '0;
         n_q           <= '0;
         res_gcd_q     <= '0;
         res_timeout_q <= 1'b0;
         load_q        <= 1'b0;
         res_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         m_q           <= m_d;
         n_q           <= n_d;
         res_gcd_q     <= res_gcd_d;
         res_timeout_q <= res_timeout_d;
         load_q        <= load_d;
         res_valid_q   <= res_valid_d;
         busy_q        <= busy_d;
         cnt_q         <= cnt_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign M           = m_q;
   assign N           = n_q;
   assign load        = load_q;
   assign res_valid   = res_valid_q;
   assign res_gcd     = res_gcd_q;
   assign res_timeout = res_timeout_q;
   assign busy        = busy_q;

endmodule : gcd_job_sequencer
